// File: rtl/down_counter_if.sv
// rtl/down_counter_if.sv - control/status bundle for the loadable prescaled down-counter
interface down_counter_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;

  // Controller side: issues load/start/stop, watches count and status
  modport master (
    output load, load_value, start, stop,
    input  count, busy, tc
  );

  // Counter side
  modport slave (
    input  load, load_value, start, stop,
    output count, busy, tc
  );
endinterface

// File: rtl/down_counter.sv
// rtl/down_counter.sv - loadable, prescaled down-counter with one-cycle terminal-count pulse
module down_counter #(
  parameter int WIDTH       = 4,
  parameter int PRESCALE    = 1,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  down_counter_if.slave bus
);

  // A prescale of zero would never produce a tick; refuse to build it.
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("down_counter: PRESCALE must be >= 1");
  end

  // Prescaler needs at least one bit even when PRESCALE == 1.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO    = '0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tc_q, tc_d;

  // State, count, reload, prescaler and tc registers; async reset clears everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      pre_q    <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      pre_q    <= pre_d;
      tc_q     <= tc_d;
    end
  end

  // Next-state logic with priority load > stop > start > tick
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    pre_d    = pre_q;
    tc_d     = 1'b0;

    if (bus.load) begin
      // Load aborts any count in progress and never raises tc.
      count_d  = bus.load_value;
      reload_d = bus.load_value;
      pre_d    = '0;
      state_d  = IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.stop) begin
            // Pausing wins even over a terminal tick due on this edge.
            state_d = IDLE;
            pre_d   = '0;
          end else if (pre_q == PRE_MAX) begin
            pre_d = '0;
            if (count_q == ONE) begin
              tc_d = 1'b1;
              if (AUTO_RELOAD) begin
                count_d = reload_q;
              end else begin
                count_d = ZERO;
                state_d = IDLE;
              end
            end else if (count_q != ZERO) begin
              count_d = count_q - ONE;
            end
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
        default: begin
          // A zero count cannot be started; start with stop is a no-op.
          if (bus.start && !bus.stop && (count_q != ZERO)) begin
            state_d = RUN;
            pre_d   = '0;
          end
        end
      endcase
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = (state_q == RUN);
  assign bus.tc    = tc_q;

endmodule

// File: tb/tb_down_counter.sv
// tb/tb_down_counter.sv - randomized and directed self-check of down_counter against a behavioural model
module tb_down_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  down_counter_if #(.WIDTH(4)) if0 ();
  down_counter_if #(.WIDTH(4)) if1 ();

  down_counter #(.WIDTH(4), .PRESCALE(1), .AUTO_RELOAD(1'b0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  down_counter #(.WIDTH(4), .PRESCALE(3), .AUTO_RELOAD(1'b1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // Behavioural reference: one entry per instance
  int m_pre[2] = '{1, 3};
  int m_ar[2]  = '{0, 1};
  int m_count[2];
  int m_reload[2];
  int m_run[2];
  int m_elapsed[2];
  int m_tc[2];
  int tc_seen[2];

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_count[i]   = 0;
      m_reload[i]  = 0;
      m_run[i]     = 0;
      m_elapsed[i] = 0;
      m_tc[i]      = 0;
    end
  endtask

  // One clock edge of the reference, from the rules in plain arithmetic
  task automatic model_edge(input int ld, input int lv, input int st, input int sp);
    for (int i = 0; i < 2; i++) begin
      m_tc[i] = 0;
      if (ld != 0) begin
        m_count[i]   = lv;
        m_reload[i]  = lv;
        m_run[i]     = 0;
        m_elapsed[i] = 0;
      end else if (m_run[i] != 0) begin
        if (sp != 0) begin
          m_run[i]     = 0;
          m_elapsed[i] = 0;
        end else begin
          m_elapsed[i]++;
          if (m_elapsed[i] % m_pre[i] == 0) begin
            if (m_count[i] == 1) begin
              m_tc[i] = 1;
              if (m_ar[i] != 0) m_count[i] = m_reload[i];
              else begin
                m_count[i] = 0;
                m_run[i]   = 0;
              end
            end else if (m_count[i] > 1) begin
              m_count[i] = m_count[i] - 1;
            end
          end
        end
      end else if (st != 0 && sp == 0 && m_count[i] != 0) begin
        m_run[i]     = 1;
        m_elapsed[i] = 0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check($sformatf("%s.count0", tag), int'(if0.count), m_count[0]);
    check($sformatf("%s.busy0",  tag), int'(if0.busy),  m_run[0]);
    check($sformatf("%s.tc0",    tag), int'(if0.tc),    m_tc[0]);
    check($sformatf("%s.count1", tag), int'(if1.count), m_count[1]);
    check($sformatf("%s.busy1",  tag), int'(if1.busy),  m_run[1]);
    check($sformatf("%s.tc1",    tag), int'(if1.tc),    m_tc[1]);
  endtask

  // Apply one set of inputs across one rising edge, then compare at the falling edge
  task automatic step(input string tag, input logic ld, input logic [3:0] lv,
                      input logic st, input logic sp);
    if0.load = ld; if0.load_value = lv; if0.start = st; if0.stop = sp;
    if1.load = ld; if1.load_value = lv; if1.start = st; if1.stop = sp;
    @(posedge clk);
    model_edge(int'(ld), int'(lv), int'(st), int'(sp));
    @(negedge clk);
    if (if0.tc) tc_seen[0]++;
    if (if1.tc) tc_seen[1]++;
    compare_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  // Assert reset between edges, check it acts at once, release on a later falling edge
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all({tag, ".during"});
    @(negedge clk);
    rst = 1'b0;
    compare_all({tag, ".after"});
  endtask

  initial begin
    if0.load = 1'b0; if0.load_value = '0; if0.start = 1'b0; if0.stop = 1'b0;
    if1.load = 1'b0; if1.load_value = '0; if1.start = 1'b0; if1.stop = 1'b0;
    tc_seen[0] = 0;
    tc_seen[1] = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all("reset");
    rst = 1'b0;

    // Reset mid-run, then start on a zero count is ignored
    step("rst_mid", 1'b1, 4'd9, 1'b0, 1'b0);
    step("rst_mid", 1'b0, 4'd0, 1'b1, 1'b0);
    idle("rst_mid", 3);
    check("rst_mid.count_before", int'(if0.count), 6);
    async_reset("rst_mid");
    step("rst_mid.start0", 1'b0, 4'd0, 1'b1, 1'b0);
    check("rst_mid.still_zero", int'(if0.count), 0);

    // Basic one-shot from 3
    step("oneshot", 1'b1, 4'd3, 1'b0, 1'b0);
    step("oneshot", 1'b0, 4'd0, 1'b1, 1'b0);
    tc_seen[0] = 0;
    idle("oneshot", 4);
    check("oneshot.tc_pulses", tc_seen[0], 1);
    check("oneshot.final", int'(if0.count), 0);

    // Prescale 3 with auto-reload: four periods of 6 cycles
    step("reload", 1'b1, 4'd2, 1'b0, 1'b0);
    step("reload", 1'b0, 4'd0, 1'b1, 1'b0);
    tc_seen[1] = 0;
    idle("reload", 24);
    check("reload.tc_pulses", tc_seen[1], 4);
    check("reload.count", int'(if1.count), 2);

    // Stop, hold, simultaneous start+stop, then resume
    step("stop", 1'b1, 4'd5, 1'b0, 1'b0);
    step("stop", 1'b0, 4'd0, 1'b1, 1'b0);
    idle("stop", 2);
    check("stop.at3", int'(if0.count), 3);
    step("stop", 1'b0, 4'd0, 1'b0, 1'b1);
    idle("stop.hold", 10);
    check("stop.held", int'(if0.count), 3);
    step("stop.both", 1'b0, 4'd0, 1'b1, 1'b1);
    check("stop.both_idle", int'(if0.busy), 0);
    step("resume", 1'b0, 4'd0, 1'b1, 1'b0);
    tc_seen[0] = 0;
    idle("resume", 5);
    check("resume.tc_pulses", tc_seen[0], 1);

    // Stop on the terminal tick edge
    step("stop_tc", 1'b1, 4'd2, 1'b0, 1'b0);
    step("stop_tc", 1'b0, 4'd0, 1'b1, 1'b0);
    step("stop_tc", 1'b0, 4'd0, 1'b0, 1'b0);
    step("stop_tc", 1'b0, 4'd0, 1'b0, 1'b1);
    check("stop_tc.held1", int'(if0.count), 1);
    idle("stop_tc", 2);

    // Load overrides a running count; zero load cannot be started
    step("ovr", 1'b1, 4'd6, 1'b0, 1'b0);
    step("ovr", 1'b0, 4'd0, 1'b1, 1'b0);
    idle("ovr", 2);
    step("ovr.load15", 1'b1, 4'd15, 1'b1, 1'b0);
    check("ovr.count15", int'(if0.count), 15);
    step("ovr.load0", 1'b1, 4'd0, 1'b0, 1'b0);
    step("ovr.start0", 1'b0, 4'd0, 1'b1, 1'b0);
    idle("ovr", 2);

    // Full range from 15 with no wrap
    step("full", 1'b1, 4'd15, 1'b0, 1'b0);
    step("full", 1'b0, 4'd0, 1'b1, 1'b0);
    tc_seen[0] = 0;
    idle("full", 18);
    check("full.tc_pulses", tc_seen[0], 1);
    check("full.final", int'(if0.count), 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        async_reset("rnd.rst");
      end else begin
        step("rnd",
             logic'($urandom_range(0, 99) < 5),
             4'($urandom_range(0, 15)),
             logic'($urandom_range(0, 99) < 20),
             logic'($urandom_range(0, 99) < 5));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
Loadable, prescaled down-counter. It is the count-down counterpart of the team's 4-bit up-count/adder block. Software or a controller loads a value and starts it. The block decrements once per PRESCALE enabled cycles and emits a one-cycle terminal-count pulse on reaching zero. It is used as an event timer, for example refractory-period or inter-spike timing, next to the adder/counter datapath.

Parameters:
WIDTH, 4, width of count, load_value and the reload register
PRESCALE, 1, clock cycles per decrement in RUN; must be >= 1 (elaboration error otherwise)
AUTO_RELOAD, 0, 1 = reload from the reload register at terminal count and keep running; 0 = stop at zero

Ports:
clk  input  1  single clock, all state updates on posedge
rst  input  1  asynchronous, active-high reset
load  input  1  capture load_value into count and the reload register
load_value  input  WIDTH  value to load (unsigned)
start  input  1  begin or resume counting
stop  input  1  pause counting
count  output  WIDTH  current count value (registered)
busy  output  1  high while in RUN
tc  output  1  one-cycle terminal-count pulse (registered)

Behaviour:
- Reset (async, rst=1):
  - count=0, reload register=0, prescaler=0, state=IDLE
  - busy=0, tc=0
  - These values hold while rst is high, and the first edge after rst falls is an ordinary edge.
- States:
  - IDLE: count held.
  - RUN: counting; busy=1.
- Priority each edge: load > stop > start > tick.
- load (any state):
  - count <= load_value, reload <= load_value, prescaler <= 0, state <= IDLE, tc <= 0.
  - An in-progress count is aborted with no tc.
- stop in RUN:
  - state <= IDLE, count held, prescaler <= 0, no tc, even if a terminal tick was due this edge.
  - stop in IDLE has no effect.
- start in IDLE with count != 0:
  - state <= RUN, prescaler <= 0; busy is high from that edge onward.
  - start with count == 0 is ignored: stays IDLE, no tc.
  - start in RUN is ignored.
  - start and stop asserted together: stop wins.
- Tick: in RUN, when prescaler == PRESCALE-1 the prescaler clears to 0 and a decrement occurs; otherwise the prescaler increments.
  - The first decrement happens PRESCALE edges after the edge that sampled start.
- Decrement with count > 1: count <= count-1.
- Terminal tick (count == 1):
  - tc <= 1 for exactly one cycle.
  - AUTO_RELOAD=0: count <= 0, state <= IDLE, busy <= 0.
  - AUTO_RELOAD=1: count <= reload, stay in RUN, so the tc period is reload*PRESCALE cycles.
- tc is 0 on every edge that is not a terminal tick.
- Count never wraps below zero. Unsigned arithmetic is truncated to WIDTH with no underflow path.
- A load_value of 0 followed by start leaves the block in IDLE.

Test Plan:
- Reset mid-run: WIDTH=4, PRESCALE=1; load 9, start, after 3 decrements assert rst asynchronously between edges -> count=0, busy=0, tc=0 immediately; start afterwards ignored (count=0).
- Basic one-shot: WIDTH=4, PRESCALE=1, AUTO_RELOAD=0; load 3, start at edge 0 -> count 2,1,0 after edges 1,2,3; tc=1 only in the cycle after edge 3; busy falls after edge 3.
- Prescale plus auto-reload: PRESCALE=3, AUTO_RELOAD=1; load 2, start -> decrement every 3 edges; tc pulses every 6 cycles with count reloading to 2; run 4 periods -> 4 tc pulses.
- Stop/resume and simultaneous events:
  - load 5, start; stop after count=3 -> count holds at 3 for 10 cycles with busy=0.
  - start and stop on the same edge -> stays IDLE.
  - start alone -> resumes 3,2,1,0 with one tc.
- Stop on terminal tick: count=1 and stop asserted on the tick edge -> count stays 1, no tc, IDLE.
- Load overrides: during RUN at count=4, assert load=15 together with start -> count=15, IDLE, no tc; start with load_value=0 loaded -> ignored.
- Full range: WIDTH=4, load 15, PRESCALE=1 -> exactly 15 decrements to 0 with no wrap to 15 (AUTO_RELOAD=0).
